sr_task_queue_prio: RTL and testbench

Parametrised shift-register task queue for the hardware scheduler: holds up to DEPTH tasks sorted by deadline key, ages all keys on a scheduler tick, tracks per-task blocked/active state, and presents the earliest-deadline ready task at the head. It sits between the task-control unit, which issues enqueue/remove/block commands, and the dispatcher, which pops the head. It supersedes single-cell queue tails with a complete, depth-configurable queue and per-task blocking.

---
 rtl/sr_task_queue_prio_pkg.sv | 35 +++
 rtl/sr_task_queue_prio_if.sv | 51 +++++
 rtl/sr_task_queue_prio_cell.sv | 72 +++++++
 rtl/sr_task_queue_prio.sv | 202 ++++++++++++++++++++
 tb/tb_sr_task_queue_prio.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_task_queue_prio_pkg.sv
// rtl/sr_task_queue_prio_pkg.sv - shared types and constants for the deadline-sorted task queue
//
// Purpose: per-slot shift-op encoding, error-bit indices and entry layout helpers.
// Entry layout (packed, MSB first): {valid, ready, tid[TID_W], key[KEY_W]}.
// A package typedef cannot carry module parameters, so the entry is a flat
// vector of entry_width(TID_W, KEY_W) bits and the offsets below locate each field.
package sr_task_queue_pkg;

  typedef enum logic [1:0] {
    HOLD       = 2'd0,  // keep own entry
    LOAD_NEW   = 2'd1,  // capture the enqueued entry
    TAKE_LOWER = 2'd2,  // take entry from slot i-1 (insert shifts up)
    TAKE_UPPER = 2'd3   // take entry from slot i+1 (delete compacts down)
  } shift_op_e;

  localparam int ERR_OVERFLOW  = 0;
  localparam int ERR_UNDERFLOW = 1;
  localparam int ERR_NOMATCH   = 2;
  localparam int ERR_DUP       = 3;
  localparam int ERR_COLLISION = 4;
  localparam int ERR_NUM       = 5;

  function automatic int entry_width(input int tid_w, input int key_w);
    return tid_w + key_w + 2;
  endfunction

  function automatic int valid_bit(input int tid_w, input int key_w);
    return tid_w + key_w + 1;
  endfunction

  function automatic int ready_bit(input int tid_w, input int key_w);
    return tid_w + key_w;
  endfunction

endpackage

// File: rtl/sr_task_queue_prio_if.sv
// rtl/sr_task_queue_prio_if.sv - command and status bundle of the task queue
//
// Purpose: groups task-control commands, dispatcher pop and queue status.
// master: drives tick/enq/deq/rm/blk, observes head/status/error pulses.
// slave : the queue itself.
interface sr_task_queue_prio_if #(
  parameter int DEPTH = 8,
  parameter int TID_W = 4,
  parameter int KEY_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             tick;
  logic             enq_valid;
  logic [TID_W-1:0] enq_tid;
  logic [KEY_W-1:0] enq_key;
  logic             deq;
  logic             rm_valid;
  logic [TID_W-1:0] rm_tid;
  logic             blk_valid;
  logic [TID_W-1:0] blk_tid;
  logic             blk_set;

  logic             head_valid;
  logic [TID_W-1:0] head_tid;
  logic [KEY_W-1:0] head_key;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             miss;
  logic             err_overflow;
  logic             err_underflow;
  logic             err_nomatch;
  logic             err_dup;
  logic             err_collision;

  modport master (
    output tick, enq_valid, enq_tid, enq_key, deq, rm_valid, rm_tid,
           blk_valid, blk_tid, blk_set,
    input  head_valid, head_tid, head_key, count, full, empty, miss,
           err_overflow, err_underflow, err_nomatch, err_dup, err_collision
  );

  modport slave (
    input  tick, enq_valid, enq_tid, enq_key, deq, rm_valid, rm_tid,
           blk_valid, blk_tid, blk_set,
    output head_valid, head_tid, head_key, count, full, empty, miss,
           err_overflow, err_underflow, err_nomatch, err_dup, err_collision
  );

endinterface

// File: rtl/sr_task_queue_prio_cell.sv
// rtl/sr_task_queue_prio_cell.sv - one storage slot of the shift-register task queue
//
// Purpose: holds one entry {valid, ready, tid, key}; selects its next entry from
// itself, the enqueued entry or a neighbour, ages the key on tick and applies
// a block/activate that the top resolved against the post-shift contents.
// Ports: clk, rst (sync, active-high); op (shift select); lower_e/upper_e
// (neighbour entries, zero beyond the ends); new_e (entry being enqueued);
// tick; blk_match/blk_set; ent_q (registered entry).
module sr_task_queue_cell
  import sr_task_queue_pkg::*;
#(
  parameter  int TID_W = 4,
  parameter  int KEY_W = 32,
  localparam int EW    = TID_W + KEY_W + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  shift_op_e     op,
  input  logic [EW-1:0] lower_e,
  input  logic [EW-1:0] upper_e,
  input  logic [EW-1:0] new_e,
  input  logic          tick,
  input  logic          blk_match,
  input  logic          blk_set,
  output logic [EW-1:0] ent_q
);

  localparam int VB = EW - 1;
  localparam int RB = EW - 2;

  logic [EW-1:0]    src;
  logic             age;
  logic [KEY_W-1:0] key_n;
  logic [EW-1:0]    ent_d;

  always_comb begin
    src   = ent_q;
    age   = 1'b1;
    key_n = '0;
    ent_d = '0;
    case (op)
      HOLD:       src = ent_q;
      // A freshly enqueued key is stored exactly as given, even on a tick cycle.
      LOAD_NEW: begin
        src = new_e;
        age = 1'b0;
      end
      TAKE_LOWER: src = lower_e;
      TAKE_UPPER: src = upper_e;
      default:    src = ent_q;
    endcase
    key_n = src[KEY_W-1:0];
    // Uniform saturating decrement keeps the non-decreasing order intact.
    if (tick && age && src[VB] && (key_n != '0)) begin
      key_n = key_n - KEY_W'(1);
    end
    ent_d             = src;
    ent_d[KEY_W-1:0]  = key_n;
    if (blk_match) begin
      ent_d[RB] = ~blk_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

endmodule

// File: rtl/sr_task_queue_prio.sv
// rtl/sr_task_queue_prio.sv - deadline-sorted task queue with aging, blocking and ready head
//
// Purpose: DEPTH-slot shift-register queue sorted by key; one structural op per
// cycle (rm > deq > enq), independent block/activate, key aging on tick.
// Ports: clk, rst (sync, active-high); q (slave side of sr_task_queue_prio_if):
// commands tick/enq/deq/rm/blk in, head/count/full/empty/miss and one-cycle
// error pulses out.
module sr_task_queue_prio
  import sr_task_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int TID_W = 4,
  parameter  int KEY_W = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input logic                 clk,
  input logic                 rst,
  sr_task_queue_prio_if.slave q
);

  localparam int EW = entry_width(TID_W, KEY_W);
  localparam int VB = valid_bit(TID_W, KEY_W);
  localparam int RB = ready_bit(TID_W, KEY_W);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [EW-1:0]    ent_q   [DEPTH];
  logic [EW-1:0]    ent_ext [DEPTH+2];
  logic [DEPTH-1:0] v_vec;
  logic [DEPTH-1:0] r_vec;
  logic [TID_W-1:0] tid_a   [DEPTH];
  logic [KEY_W-1:0] key_a   [DEPTH];

  // Unpack slots; ent_ext pads both ends with an empty entry so slot i sees
  // its lower neighbour at ent_ext[i] and its upper one at ent_ext[i+2].
  always_comb begin
    ent_ext[0]       = '0;
    ent_ext[DEPTH+1] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_ext[i+1] = ent_q[i];
      v_vec[i]     = ent_q[i][VB];
      r_vec[i]     = ent_q[i][RB];
      tid_a[i]     = ent_q[i][KEY_W +: TID_W];
      key_a[i]     = ent_q[i][KEY_W-1:0];
    end
  end

  // tid match vectors against pre-op state.
  logic [DEPTH-1:0] rm_hit, blk_hit, dup_hit;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rm_hit[i]  = v_vec[i] && (tid_a[i] == q.rm_tid);
      blk_hit[i] = v_vec[i] && (tid_a[i] == q.blk_tid);
      dup_hit[i] = v_vec[i] && (tid_a[i] == q.enq_tid);
    end
  end

  // Priority encoders: insert slot (first empty or first key strictly greater,
  // so equal keys keep arrival order), remove slot, first ready slot.
  logic          ins_found, rm_found, rdy_found;
  logic [IW-1:0] ins_idx, rm_idx, rdy_idx;
  always_comb begin
    ins_found = 1'b0;
    rm_found  = 1'b0;
    rdy_found = 1'b0;
    ins_idx   = '0;
    rm_idx    = '0;
    rdy_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ins_found && (!v_vec[i] || (key_a[i] > q.enq_key))) begin
        ins_found = 1'b1;
        ins_idx   = IW'(i);
      end
      if (!rm_found && rm_hit[i]) begin
        rm_found = 1'b1;
        rm_idx   = IW'(i);
      end
      if (!rdy_found && v_vec[i] && r_vec[i]) begin
        rdy_found = 1'b1;
        rdy_idx   = IW'(i);
      end
    end
  end

  logic [CNT_W-1:0] count_w;
  always_comb begin
    count_w = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_w = count_w + CNT_W'(v_vec[i]);
    end
  end

  logic full_w, enq_dup;
  assign full_w  = (count_w == CNT_W'(DEPTH));
  assign enq_dup = |dup_hit;

  // Structural op arbitration.
  logic          do_rm, do_deq, do_enq, del_en;
  logic [IW-1:0] del_idx;
  logic          enq_win;
  assign enq_win = q.enq_valid && !q.rm_valid && !q.deq;
  assign do_rm   = q.rm_valid && rm_found;
  assign do_deq  = q.deq && !q.rm_valid && rdy_found;
  assign do_enq  = enq_win && !full_w && !enq_dup;
  assign del_en  = do_rm || do_deq;
  assign del_idx = do_rm ? rm_idx : rdy_idx;

  shift_op_e op [DEPTH];
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      op[i] = HOLD;
      if (del_en && (i >= int'(del_idx))) begin
        op[i] = TAKE_UPPER;
      end else if (do_enq) begin
        if (i == int'(ins_idx)) begin
          op[i] = LOAD_NEW;
        end else if (i > int'(ins_idx)) begin
          op[i] = TAKE_LOWER;
        end
      end
    end
  end

  // Block/activate acts on whatever lands in each slot after the shift, so a
  // removed/dequeued target finds no slot and a same-cycle enqueue can match.
  logic [DEPTH+1:0] blk_ext;
  logic [DEPTH-1:0] blk_post;
  assign blk_ext = {1'b0, blk_hit, 1'b0};
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      case (op[i])
        HOLD:       blk_post[i] = blk_hit[i];
        LOAD_NEW:   blk_post[i] = (q.enq_tid == q.blk_tid);
        TAKE_LOWER: blk_post[i] = blk_ext[i];
        TAKE_UPPER: blk_post[i] = blk_ext[i+2];
        default:    blk_post[i] = 1'b0;
      endcase
      blk_post[i] = blk_post[i] && q.blk_valid;
    end
  end

  logic [EW-1:0] new_e;
  assign new_e = {1'b1, 1'b1, q.enq_tid, q.enq_key};

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    sr_task_queue_cell #(
      .TID_W (TID_W),
      .KEY_W (KEY_W)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .op        (op[g]),
      .lower_e   (ent_ext[g]),
      .upper_e   (ent_ext[g+2]),
      .new_e     (new_e),
      .tick      (q.tick),
      .blk_match (blk_post[g]),
      .blk_set   (q.blk_set),
      .ent_q     (ent_q[g])
    );
  end

  // Error pulses, registered so each is high for exactly the following cycle.
  logic [ERR_NUM-1:0] err_d, err_q;
  always_comb begin
    err_d                = '0;
    err_d[ERR_OVERFLOW]  = enq_win && full_w;
    err_d[ERR_DUP]       = enq_win && !full_w && enq_dup;
    err_d[ERR_UNDERFLOW] = q.deq && !q.rm_valid && !rdy_found;
    err_d[ERR_NOMATCH]   = (q.rm_valid && !rm_found) || (q.blk_valid && !(|blk_post));
    err_d[ERR_COLLISION] = (q.rm_valid && (q.deq || q.enq_valid)) || (q.deq && q.enq_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  logic miss_w;
  always_comb begin
    miss_w = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      miss_w = miss_w || (v_vec[i] && (key_a[i] == '0));
    end
  end

  assign q.head_valid    = rdy_found;
  assign q.head_tid      = rdy_found ? tid_a[rdy_idx] : '0;
  assign q.head_key      = rdy_found ? key_a[rdy_idx] : '0;
  assign q.count         = count_w;
  assign q.full          = full_w;
  assign q.empty         = (count_w == '0);
  assign q.miss          = miss_w;
  assign q.err_overflow  = err_q[ERR_OVERFLOW];
  assign q.err_underflow = err_q[ERR_UNDERFLOW];
  assign q.err_nomatch   = err_q[ERR_NOMATCH];
  assign q.err_dup       = err_q[ERR_DUP];
  assign q.err_collision = err_q[ERR_COLLISION];

endmodule

// File: tb/tb_sr_task_queue_prio.sv
// tb/tb_sr_task_queue_prio.sv - directed self-checking bench for sr_task_queue_prio
module tb_sr_task_queue_prio;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sr_task_queue_prio_if #(.DEPTH(8), .TID_W(4), .KEY_W(32)) qif ();

  sr_task_queue_prio #(.DEPTH(8), .TID_W(4), .KEY_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qif)
  );

  // {overflow, underflow, nomatch, dup, collision}
  logic [4:0] errs;
  assign errs = {qif.err_overflow, qif.err_underflow, qif.err_nomatch,
                 qif.err_dup, qif.err_collision};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cmds();
    qif.tick      = 1'b0;
    qif.enq_valid = 1'b0;
    qif.enq_tid   = '0;
    qif.enq_key   = '0;
    qif.deq       = 1'b0;
    qif.rm_valid  = 1'b0;
    qif.rm_tid    = '0;
    qif.blk_valid = 1'b0;
    qif.blk_tid   = '0;
    qif.blk_set   = 1'b0;
  endtask

  task automatic set_enq(input int tid, input int key);
    qif.enq_valid = 1'b1;
    qif.enq_tid   = 4'(tid);
    qif.enq_key   = 32'(key);
  endtask

  task automatic enq(input int tid, input int key);
    set_enq(tid, key);
    step();
    clr_cmds();
  endtask

  task automatic blk(input int tid, input logic set);
    qif.blk_valid = 1'b1;
    qif.blk_tid   = 4'(tid);
    qif.blk_set   = set;
    step();
    clr_cmds();
  endtask

  task automatic deq1();
    qif.deq = 1'b1;
    step();
    clr_cmds();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int fill_tid [7] = '{0, 2, 4, 6, 8, 10, 11};
  int fill_key [7] = '{50, 40, 60, 15, 5, 45, 10};

  initial begin
    clr_cmds();
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_empty", qif.empty, 1);
    chk("rst_full", qif.full, 0);
    chk("rst_count", qif.count, 0);
    chk("rst_hvalid", qif.head_valid, 0);
    chk("rst_htid", qif.head_tid, 0);
    chk("rst_hkey", qif.head_key, 0);
    chk("rst_miss", qif.miss, 0);
    chk("rst_errs", errs, 5'b00000);

    // Sorted insert: order 5(10), 3(20), 1(30)
    enq(3, 20);
    enq(5, 10);
    enq(1, 30);
    chk("ins_count", qif.count, 3);
    chk("ins_htid", qif.head_tid, 5);
    chk("ins_hkey", qif.head_key, 10);

    // Block head then pop ready entries
    blk(5, 1'b1);
    chk("blk_htid", qif.head_tid, 3);
    chk("blk_hkey", qif.head_key, 20);
    chk("blk_errs", errs, 5'b00000);
    deq1();
    chk("deq1_count", qif.count, 2);
    chk("deq1_htid", qif.head_tid, 1);
    deq1();
    chk("deq2_count", qif.count, 1);
    chk("deq2_hvalid", qif.head_valid, 0);
    deq1();
    chk("udf_errs", errs, 5'b01000);
    chk("udf_count", qif.count, 1);
    step();
    chk("udf_pulse_end", errs, 5'b00000);
    blk(5, 1'b0);
    chk("act_hvalid", qif.head_valid, 1);
    chk("act_htid", qif.head_tid, 5);
    chk("act_hkey", qif.head_key, 10);

    // Collision: rm wins over deq and enq
    enq(3, 20);
    qif.rm_valid = 1'b1;
    qif.rm_tid   = 4'd3;
    qif.deq      = 1'b1;
    set_enq(7, 1);
    step();
    clr_cmds();
    chk("col_errs", errs, 5'b00001);
    chk("col_count", qif.count, 1);
    chk("col_htid", qif.head_tid, 5);
    qif.rm_valid = 1'b1;
    qif.rm_tid   = 4'd9;
    step();
    clr_cmds();
    chk("nomatch_errs", errs, 5'b00100);
    chk("nomatch_count", qif.count, 1);

    // Fill to DEPTH: 8(5),5(10),11(10),6(15),2(40),10(45),0(50),4(60)
    for (int i = 0; i < 7; i++) begin
      enq(fill_tid[i], fill_key[i]);
    end
    chk("fill_count", qif.count, 8);
    chk("fill_full", qif.full, 1);
    chk("fill_htid", qif.head_tid, 8);
    enq(12, 1);
    chk("ovf_errs", errs, 5'b10000);
    chk("ovf_count", qif.count, 8);
    chk("ovf_htid", qif.head_tid, 8);
    // Full with same-cycle deq: deq wins, enq flagged as collision only
    qif.deq = 1'b1;
    set_enq(12, 1);
    step();
    clr_cmds();
    chk("fdeq_errs", errs, 5'b00001);
    chk("fdeq_count", qif.count, 7);
    chk("fdeq_htid", qif.head_tid, 5);
    deq1();
    chk("tie_htid", qif.head_tid, 11);
    chk("tie_hkey", qif.head_key, 10);
    enq(0, 3);
    chk("dup_errs", errs, 5'b00010);
    chk("dup_count", qif.count, 6);
    chk("dup_htid", qif.head_tid, 11);

    // Aging and miss
    do_reset();
    enq(2, 2);
    chk("age0_hkey", qif.head_key, 2);
    chk("age0_miss", qif.miss, 0);
    qif.tick = 1'b1;
    step();
    chk("age1_hkey", qif.head_key, 1);
    chk("age1_miss", qif.miss, 0);
    step();
    chk("age2_hkey", qif.head_key, 0);
    chk("age2_miss", qif.miss, 1);
    set_enq(4, 9);
    step();
    clr_cmds();
    chk("age3_hkey", qif.head_key, 0);
    chk("age3_miss", qif.miss, 1);
    chk("age3_count", qif.count, 2);
    deq1();
    chk("agepop_htid", qif.head_tid, 4);
    chk("agepop_hkey", qif.head_key, 9);
    chk("agepop_miss", qif.miss, 0);

    // Block a same-cycle enqueue; block a same-cycle dequeued entry
    set_enq(6, 3);
    qif.blk_valid = 1'b1;
    qif.blk_tid   = 4'd6;
    qif.blk_set   = 1'b1;
    step();
    clr_cmds();
    chk("enqblk_errs", errs, 5'b00000);
    chk("enqblk_count", qif.count, 2);
    chk("enqblk_htid", qif.head_tid, 4);
    qif.deq       = 1'b1;
    qif.blk_valid = 1'b1;
    qif.blk_tid   = 4'd4;
    qif.blk_set   = 1'b1;
    step();
    clr_cmds();
    chk("deqblk_errs", errs, 5'b00100);
    chk("deqblk_count", qif.count, 1);
    chk("deqblk_hvalid", qif.head_valid, 0);

    // Reset overrides same-cycle commands
    enq(1, 5);
    enq(2, 6);
    enq(3, 7);
    chk("half_count", qif.count, 4);
    rst = 1'b1;
    set_enq(9, 1);
    qif.rm_valid = 1'b1;
    qif.rm_tid   = 4'd13;
    qif.deq      = 1'b1;
    step();
    rst = 1'b0;
    clr_cmds();
    chk("rst2_empty", qif.empty, 1);
    chk("rst2_count", qif.count, 0);
    chk("rst2_hvalid", qif.head_valid, 0);
    chk("rst2_errs", errs, 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
